mod_counter_seq: RTL and testbench

Sequencer and configuration controller for a programmable modulo-N step counter. The default configuration is MOD-6: the counter counts 0..5 and wraps. It accepts a modulus and a wrap budget through a config port, then runs the counter under start/pause/abort control. It reports wraps, progress and completion to the surrounding control logic. The counter register is internal and is exposed as an output.

---
 rtl/mod_counter_seq.sv | 125 ++++++++++++
 tb/tb_mod_counter_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_seq.sv
// Programmable modulo-N step counter with a config port and a start/pause/abort run sequencer.
// Reports wraps, wrap count, run state and rejected config writes. All outputs are registered.
module mod_counter_seq #(
  parameter int unsigned CW = 3,
  parameter int unsigned WW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_mod,
  input  logic [WW-1:0] cfg_wraps,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic [WW-1:0] wrap_cnt,
  output logic [1:0]    state,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_mod;
  logic [WW-1:0] r_wraps;
  logic [WW-1:0] r_wrap_cnt;
  logic          r_wrap;
  logic          r_busy;
  logic          r_done;
  logic          r_cfg_err;

  logic          w_cfg_ok;
  logic          w_at_term;
  logic [WW-1:0] w_wrap_cnt_nxt;

  // Config writes only land while no run is active, and a zero modulus is illegal.
  assign w_cfg_ok       = ((r_state == S_IDLE) || (r_state == S_DONE)) && (cfg_mod != '0);
  assign w_at_term      = (r_count == r_mod);
  assign w_wrap_cnt_nxt = r_wrap_cnt + WW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_mod      <= CW'(5);
      r_wraps    <= WW'(1);
      r_wrap_cnt <= '0;
      r_wrap     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_count    <= '0;
        r_wrap_cnt <= '0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else if (start) begin
        // A write in the same cycle as start loses and is reported as rejected.
        r_state    <= S_RUN;
        r_count    <= '0;
        r_wrap_cnt <= '0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_cfg_err  <= cfg_we;
      end else begin
        if (cfg_we) begin
          if (w_cfg_ok) begin
            r_mod   <= cfg_mod;
            r_wraps <= cfg_wraps;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
        unique case (r_state)
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSE;
            end else if (w_at_term) begin
              r_count    <= '0;
              r_wrap     <= 1'b1;
              r_wrap_cnt <= w_wrap_cnt_nxt;
              // A zero budget means the run continues until aborted.
              if ((r_wraps != '0) && (w_wrap_cnt_nxt == r_wraps)) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              r_state <= S_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign wrap_cnt = r_wrap_cnt;
  assign state    = r_state;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_mod_counter_seq.sv
// Directed bench for mod_counter_seq: outputs are packed as {count,wrap,wrap_cnt,state,busy,done,cfg_err}
// and compared #1 after each rising edge against hand-computed values.
module tb_mod_counter_seq;

  logic       clk = 1'b0;
  logic       reset, cfg_we, start, pause, abort;
  logic [2:0] cfg_mod;
  logic [3:0] cfg_wraps;
  logic [2:0] count;
  logic       wrap;
  logic [3:0] wrap_cnt;
  logic [1:0] state;
  logic       busy, done, cfg_err;
  logic [12:0] obs;

  int n_vec = 0;
  int n_err = 0;

  mod_counter_seq #(.CW(3), .WW(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mod(cfg_mod), .cfg_wraps(cfg_wraps),
    .start(start), .pause(pause), .abort(abort),
    .count(count), .wrap(wrap), .wrap_cnt(wrap_cnt), .state(state),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  assign obs = {count, wrap, wrap_cnt, state, busy, done, cfg_err};

  function automatic logic [12:0] ev(input int c, input int w, input int wc, input int st,
                                     input int b, input int d, input int e);
    return {3'(c), 1'(w), 4'(wc), 2'(st), 1'(b), 1'(d), 1'(e)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset: got %h exp %h", obs, e); end
  endtask

  task automatic test_default_run();
    logic [12:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    e = ev(0, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL default_start: got %h exp %h", obs, e); end
    for (int k = 1; k <= 5; k++) begin
      step();
      e = ev(k, 0, 0, 1, 1, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL default_count%0d: got %h exp %h", k, obs, e); end
    end
    step();
    e = ev(0, 1, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL default_wrap_done: got %h exp %h", obs, e); end
    step();
    e = ev(0, 0, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL default_done_hold: got %h exp %h", obs, e); end
  endtask

  task automatic test_cfg_run();
    logic [12:0] e;
    int st;
    cfg_we = 1'b1; cfg_mod = 3'd2; cfg_wraps = 4'd3;
    step();
    cfg_we = 1'b0;
    e = ev(0, 0, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL cfg_write_in_done: got %h exp %h", obs, e); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      st = (k == 9) ? 3 : 1;
      e = ev(k % 3, (k % 3 == 0) ? 1 : 0, k / 3, st, (st == 1) ? 1 : 0, (st == 3) ? 1 : 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL cfg_run_step%0d: got %h exp %h", k, obs, e); end
    end
  endtask

  task automatic test_pause();
    logic [12:0] e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    e = ev(3, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL pause_pre: got %h exp %h", obs, e); end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      e = ev(3, 0, 0, 2, 1, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL pause_hold%0d: got %h exp %h", k, obs, e); end
    end
    pause = 1'b0;
    step();
    e = ev(3, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL pause_release: got %h exp %h", obs, e); end
    step();
    e = ev(4, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL pause_resume: got %h exp %h", obs, e); end
    step(); step();
    e = ev(0, 1, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL pause_done: got %h exp %h", obs, e); end
  endtask

  task automatic test_cfg_err();
    logic [12:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_we = 1'b1; cfg_mod = 3'd1; cfg_wraps = 4'd0;
    step();
    cfg_we = 1'b0;
    e = ev(1, 0, 0, 1, 1, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL err_in_run: got %h exp %h", obs, e); end
    step();
    e = ev(2, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL err_one_cycle: got %h exp %h", obs, e); end
    step(); step(); step();
    e = ev(5, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL err_mod_kept: got %h exp %h", obs, e); end
    step();
    e = ev(0, 1, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL err_wraps_kept: got %h exp %h", obs, e); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL abort_from_done: got %h exp %h", obs, e); end
    cfg_we = 1'b1; cfg_mod = 3'd0; cfg_wraps = 4'd5;
    step();
    cfg_we = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL err_zero_mod: got %h exp %h", obs, e); end
    // start wins over a same-cycle legal write
    cfg_we = 1'b1; cfg_mod = 3'd1; cfg_wraps = 4'd2; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    e = ev(0, 0, 0, 1, 1, 0, 1);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL start_with_cfg: got %h exp %h", obs, e); end
    for (int k = 1; k <= 5; k++) step();
    e = ev(5, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL start_cfg_mod_kept: got %h exp %h", obs, e); end
    step();
    e = ev(0, 1, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL start_cfg_done: got %h exp %h", obs, e); end
  endtask

  task automatic test_abort();
    logic [12:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    e = ev(4, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL abort_pre: got %h exp %h", obs, e); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = ev(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL abort_idle%0d: got %h exp %h", k, obs, e); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    e = ev(0, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL restart: got %h exp %h", obs, e); end
    step(); step();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL start_abort: got %h exp %h", obs, e); end
  endtask

  task automatic test_rollover();
    logic [12:0] e;
    cfg_we = 1'b1; cfg_mod = 3'd1; cfg_wraps = 4'd0;
    step();
    cfg_we = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL roll_cfg: got %h exp %h", obs, e); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      e = ev(k % 2, (k % 2 == 0) ? 1 : 0, (k / 2) % 16, 1, 1, 0, 0);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL roll_step%0d: got %h exp %h", k, obs, e); end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_midrun: got %h exp %h", obs, e); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    e = ev(5, 0, 0, 1, 1, 0, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_restores_mod: got %h exp %h", obs, e); end
    step();
    e = ev(0, 1, 1, 3, 0, 1, 0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_restores_wraps: got %h exp %h", obs, e); end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_mod = '0; cfg_wraps = '0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    test_reset();
    test_default_run();
    test_cfg_run();
    test_pause();
    test_cfg_err();
    test_abort();
    test_back_to_back();
    test_rollover();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
